fwft_sfifo_mch: RTL and testbench
=================================

Name: fwft_sfifo_mch

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO bank.
- Holds CH_NUM independent logical queues behind one shared write port and one shared read port, each port with a channel select.
- Used wherever several streams in one clock domain need per-channel buffering without instantiating one vendor FIFO per stream.
- Provides per-channel status, sticky error reporting and optional parity protection.

Parameters:
- CH_NUM, 4, number of logical channels; must be >=2.
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 32, words per channel; must be a power of two, >=4.
- PROG_FULL_THRESH, DEPTH-8, per-channel afull assert level; legal range 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH)+1, per-channel occupancy count width.
- CH_WIDTH, $clog2(CH_NUM), channel select width (derived, not overridable).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wen  in  1  write request.
- wch  in  CH_WIDTH  write channel select.
- wdata  in  DATA_WIDTH  write data.
- inject_perr  in  1  with wen, store inverted parity (used only with FIFO_PARITY_EN).
- full  out  CH_NUM  per-channel full.
- afull  out  CH_NUM  per-channel programmable full.
- ren  in  1  read accept for channel rch.
- rch  in  CH_WIDTH  read channel select.
- rdata  out  DATA_WIDTH  head word of channel rch (FWFT).
- empty  out  CH_NUM  per-channel empty.
- cnt  out  CH_NUM*CNT_WIDTH  per-channel occupancy; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.
- err  out  1  sticky parity error.

Behaviour:
Reset (rst_n==0 at a clock edge):
- All pointers and counts go to 0.
- empty = all 1; full = 0; afull = 0; cnt = 0; overflow = 0; underflow = 0; err = 0.
- Memory contents are not cleared.
- A reset mid-traffic discards all queued words; any wen/ren in the reset cycle is ignored.

Storage and read port:
- Storage is a flop/distributed array of CH_NUM*DEPTH words, plus one parity bit per word when FIFO_PARITY_EN is defined.
- Each channel has its own write pointer, read pointer (log2(DEPTH) bits, natural wrap) and count.
- rdata is the combinational head word of channel rch; it reads 0 whenever empty[rch]==1.

Write rules:
- A write is accepted iff wen==1, wch<CH_NUM and full[wch]==0, all sampled at the edge.
- An accepted write stores wdata, increments the write pointer and count.
- The word is visible on rdata and empty clears in cycle N+1 for a write in cycle N (write-to-read latency 1).

Read rules:
- A read is accepted iff ren==1, rch<CH_NUM and empty[rch]==0.
- An accepted read advances the read pointer and decrements the count; the next word appears on rdata in the following cycle.

Simultaneous events:
- Write and read on different channels: both proceed.
- Same channel, count>0 and not full: both proceed; count unchanged.
- Same channel while empty: the write is accepted, the read is rejected (no bypass).
- Same channel while full: the read is accepted, the write is rejected (no look-ahead on freed slot).

Status:
- full[i] = (cnt_i==DEPTH).
- empty[i] = (cnt_i==0).
- afull[i] = (cnt_i>=PROG_FULL_THRESH).
- All status is decoded from registered counts and updates one cycle after the causing access.

Error pulses:
- overflow: registered pulse in cycle N+1 for any rejected wen in cycle N (full or out-of-range wch).
- underflow: the same rule for rejected ren.
- Rejected accesses change no state.

Optional Feature:
Macro FIFO_PARITY_EN.
- Defined:
  - Each write stores the even parity of wdata, inverted when inject_perr==1.
  - On every accepted read, the stored parity is checked against the head word.
  - A mismatch sets err in the next cycle; err stays set until reset.
- Undefined:
  - No parity storage.
  - inject_perr is ignored.
  - err is tied to 0.

Test Plan:
- Reset, then write 0xA5A5_0001..0xA5A5_0003 to ch2 → empty[2] falls 1 cycle after the first write; cnt[2]=3; rdata with rch=2 reads 0xA5A5_0001, then each ren advances to 0x…0002, 0x…0003; empty[2]=1 afterwards; other channels untouched.
- Fill ch0 with DEPTH=32 words → afull[0] rises after the 24th write, full[0] after the 32nd; a 33rd wen gives overflow=1 for one cycle and cnt[0] stays 32.
- ren on empty ch1 → underflow pulse; cnt[1] stays 0. Write to ch1 and ren on ch1 in the same cycle while empty → underflow; the write lands, cnt[1]=1.
- With ch3 full, issue wen and ren on ch3 in the same cycle → overflow pulse; cnt[3]=31. Interleaved writes to ch0 and reads from ch1 each cycle for 100 cycles → per-channel order preserved against a scoreboard.
- With FIFO_PARITY_EN: write 0x1234_5678 with inject_perr=1 to ch0, then read it → err=1 the cycle after the read and held; drive rst_n=0 → err=0, all cnt=0, empty all 1. Without the macro, err stays 0.

Source files
------------

// File: rtl/fwft_sfifo_mch.sv
// ============================================================================
// Module      : fwft_sfifo_mch
// Description : Single-clock FWFT FIFO bank with CH_NUM logical queues behind
//               one shared write port and one shared read port. Optional word
//               parity is enabled with the FIFO_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwft_sfifo_mch #(
    parameter  int CH_NUM           = 4,
    parameter  int DATA_WIDTH       = 32,
    parameter  int DEPTH            = 32,
    parameter  int PROG_FULL_THRESH = DEPTH - 8,
    parameter  int CNT_WIDTH        = $clog2(DEPTH) + 1,
    localparam int CH_WIDTH         = $clog2(CH_NUM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wen,
    input  logic [CH_WIDTH-1:0]           wch,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          inject_perr,
    output logic [CH_NUM-1:0]             full,
    output logic [CH_NUM-1:0]             afull,
    input  logic                          ren,
    input  logic [CH_WIDTH-1:0]           rch,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [CH_NUM-1:0]             empty,
    output logic [CH_NUM*CNT_WIDTH-1:0]   cnt,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          err
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_WORDS  = CH_NUM * DEPTH;
    localparam int c_ADDR_W = $clog2(c_WORDS);
    localparam logic [CNT_WIDTH-1:0] c_DEPTH  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_THRESH = CNT_WIDTH'(PROG_FULL_THRESH);

    logic [DATA_WIDTH-1:0] r_mem  [c_WORDS];
    logic [c_PTR_W-1:0]    r_wptr [CH_NUM];
    logic [c_PTR_W-1:0]    r_rptr [CH_NUM];
    logic [CNT_WIDTH-1:0]  r_cnt  [CH_NUM];

    logic [CH_NUM-1:0]     w_wr_hit;
    logic [CH_NUM-1:0]     w_rd_hit;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_rd_valid;
    logic [c_ADDR_W-1:0]   w_waddr;
    logic [c_ADDR_W-1:0]   w_raddr;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  r_overflow;
    logic                  r_underflow;

    // Channel-select decode; an out-of-range select matches no channel.
    always_comb begin
        w_waddr    = '0;
        w_raddr    = '0;
        w_rd_valid = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (wch == CH_WIDTH'(i)) begin
                w_waddr = c_ADDR_W'(i * DEPTH) + c_ADDR_W'(r_wptr[i]);
            end
            if (rch == CH_WIDTH'(i)) begin
                w_raddr    = c_ADDR_W'(i * DEPTH) + c_ADDR_W'(r_rptr[i]);
                w_rd_valid = (r_cnt[i] != '0);
            end
        end
    end

    assign w_wr_ok = |w_wr_hit;
    assign w_rd_ok = |w_rd_hit;
    assign w_head  = r_mem[w_raddr];
    assign rdata   = w_rd_valid ? w_head : '0;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign w_wr_hit[gi] = wen && (wch == CH_WIDTH'(gi)) && (r_cnt[gi] != c_DEPTH);
            assign w_rd_hit[gi] = ren && (rch == CH_WIDTH'(gi)) && (r_cnt[gi] != '0);

            assign full[gi]  = (r_cnt[gi] == c_DEPTH);
            assign empty[gi] = (r_cnt[gi] == '0);
            assign afull[gi] = (r_cnt[gi] >= c_THRESH);
            assign cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wptr[gi] <= '0;
                    r_rptr[gi] <= '0;
                    r_cnt[gi]  <= '0;
                end else begin
                    if (w_wr_hit[gi]) begin
                        r_wptr[gi] <= r_wptr[gi] + 1'b1;
                    end
                    if (w_rd_hit[gi]) begin
                        r_rptr[gi] <= r_rptr[gi] + 1'b1;
                    end
                    if (w_wr_hit[gi] && !w_rd_hit[gi]) begin
                        r_cnt[gi] <= r_cnt[gi] + 1'b1;
                    end else if (!w_wr_hit[gi] && w_rd_hit[gi]) begin
                        r_cnt[gi] <= r_cnt[gi] - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Storage has no reset: stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wen && !w_wr_ok;
            r_underflow <= ren && !w_rd_ok;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef FIFO_PARITY_EN
    logic r_par [c_WORDS];
    logic r_err;

    // Even parity of the word, optionally inverted to exercise the checker.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_par[w_waddr] <= (^wdata) ^ inject_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_rd_ok && ((^w_head) != r_par[w_raddr])) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_perr;
    assign w_unused_perr = inject_perr;
    assign err           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwft_sfifo_mch.sv
// ============================================================================
// Module      : tb_fwft_sfifo_mch
// Description : Directed self-checking bench for fwft_sfifo_mch (default
//               parameters; FIFO_PARITY_EN adds the parity scenario).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwft_sfifo_mch;

    localparam int c_CW = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [1:0]  wch;
    logic [31:0] wdata;
    logic        inject_perr;
    logic [3:0]  full;
    logic [3:0]  afull;
    logic        ren;
    logic [1:0]  rch;
    logic [31:0] rdata;
    logic [3:0]  empty;
    logic [23:0] cnt;
    logic        overflow;
    logic        underflow;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    fwft_sfifo_mch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (wen),
        .wch         (wch),
        .wdata       (wdata),
        .inject_perr (inject_perr),
        .full        (full),
        .afull       (afull),
        .ren         (ren),
        .rch         (rch),
        .rdata       (rdata),
        .empty       (empty),
        .cnt         (cnt),
        .overflow    (overflow),
        .underflow   (underflow),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] cnt_of(input int ch);
        return cnt[ch*c_CW +: c_CW];
    endfunction

    // One clock: inputs are held across the edge, outputs sampled 1 ns later.
    task automatic cyc(input logic we, input logic [1:0] wc, input logic [31:0] wd,
                       input logic re, input logic [1:0] rc);
        wen   = we;
        wch   = wc;
        wdata = wd;
        ren   = re;
        rch   = rc;
        @(posedge clk);
        #1;
        wen         = 1'b0;
        ren         = 1'b0;
        inject_perr = 1'b0;
    endtask

    task automatic peek(input logic [1:0] rc);
        rch = rc;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 2'd0, 32'hDEAD_BEEF, 1'b1, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        wen         = 1'b0;
        wch         = '0;
        wdata       = '0;
        inject_perr = 1'b0;
        ren         = 1'b0;
        rch         = '0;

        do_reset();
        peek(2'd0);
        check_eq("rst_empty", empty, 4'hF);
        check_eq("rst_full", full, 4'h0);
        check_eq("rst_afull", afull, 4'h0);
        check_eq("rst_cnt", cnt, 24'h0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_unf", underflow, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_rdata", rdata, 32'h0);

        // Three words into ch2, drained in order.
        cyc(1'b1, 2'd2, 32'hA5A5_0001, 1'b0, 2'd0);
        check_eq("ch2_empty_fall", empty, 4'b1011);
        cyc(1'b1, 2'd2, 32'hA5A5_0002, 1'b0, 2'd0);
        cyc(1'b1, 2'd2, 32'hA5A5_0003, 1'b0, 2'd0);
        check_eq("ch2_cnt3", cnt_of(2), 6'd3);
        check_eq("ch2_others", {cnt_of(0), cnt_of(1), cnt_of(3)}, 18'h0);
        peek(2'd2);
        check_eq("ch2_head1", rdata, 32'hA5A5_0001);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        check_eq("ch2_head2", rdata, 32'hA5A5_0002);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        check_eq("ch2_head3", rdata, 32'hA5A5_0003);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        check_eq("ch2_empty_again", empty, 4'hF);
        check_eq("ch2_rdata_zero", rdata, 32'h0);

        // Fill ch0 to the brim and past it.
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, 2'd0, 32'h0000_1000 + k, 1'b0, 2'd0);
            if (k == 23) check_eq("ch0_afull_23", afull[0], 1'b0);
            if (k == 24) check_eq("ch0_afull_24", afull[0], 1'b1);
            if (k == 31) check_eq("ch0_full_31", full[0], 1'b0);
        end
        check_eq("ch0_full_32", full, 4'b0001);
        check_eq("ch0_ovf_quiet", overflow, 1'b0);
        cyc(1'b1, 2'd0, 32'hBAD0_0000, 1'b0, 2'd0);
        check_eq("ch0_ovf_pulse", overflow, 1'b1);
        check_eq("ch0_cnt_32", cnt_of(0), 6'd32);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        check_eq("ch0_ovf_clear", overflow, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            peek(2'd0);
            check_eq("ch0_drain", rdata, 32'h0000_1000 + k);
            cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        end
        check_eq("ch0_drained", empty[0], 1'b1);

        // Read on empty ch1, then same-cycle write+read on empty ch1.
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        check_eq("ch1_unf_pulse", underflow, 1'b1);
        check_eq("ch1_cnt_0", cnt_of(1), 6'd0);
        cyc(1'b1, 2'd1, 32'h1111_2222, 1'b1, 2'd1);
        check_eq("ch1_wr_rd_unf", underflow, 1'b1);
        check_eq("ch1_wr_rd_ovf", overflow, 1'b0);
        check_eq("ch1_cnt_1", cnt_of(1), 6'd1);
        peek(2'd1);
        check_eq("ch1_head", rdata, 32'h1111_2222);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        check_eq("ch1_unf_clear", underflow, 1'b0);

        // Full ch3: simultaneous write+read lets only the read through.
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 2'd3, 32'h0000_3000 + k, 1'b0, 2'd0);
        end
        check_eq("ch3_full", full[3], 1'b1);
        cyc(1'b1, 2'd3, 32'hBAD3_0000, 1'b1, 2'd3);
        check_eq("ch3_ovf_pulse", overflow, 1'b1);
        check_eq("ch3_no_unf", underflow, 1'b0);
        check_eq("ch3_cnt_31", cnt_of(3), 6'd31);
        peek(2'd3);
        check_eq("ch3_head", rdata, 32'h0000_3001);

        // Interleaved traffic on ch0/ch1 against queue models.
        for (int k = 0; k < 100; k++) begin
            logic [1:0]  wc;
            logic [1:0]  rc;
            logic [31:0] wd;
            logic        re;
            wc = {1'b0, k[1]};
            rc = {1'b0, k[0]};
            wd = 32'hC000_0000 | k;
            re = (rc == 2'd0) ? (q0.size() > 0) : (q1.size() > 0);
            peek(rc);
            if (re) begin
                if (rc == 2'd0) check_eq("ilv_ch0", rdata, q0.pop_front());
                else            check_eq("ilv_ch1", rdata, q1.pop_front());
            end
            if (wc == 2'd0) q0.push_back(wd);
            else            q1.push_back(wd);
            cyc(1'b1, wc, wd, re, rc);
        end
        check_eq("ilv_cnt0", cnt_of(0), 6'(q0.size()));
        check_eq("ilv_cnt1", cnt_of(1), 6'(q1.size()));
        check_eq("ilv_cnt3", cnt_of(3), 6'd31);

        // Reset mid-traffic discards everything.
        do_reset();
        check_eq("mid_rst_cnt", cnt, 24'h0);
        check_eq("mid_rst_empty", empty, 4'hF);

`ifdef FIFO_PARITY_EN
        inject_perr = 1'b1;
        cyc(1'b1, 2'd0, 32'h1234_5678, 1'b0, 2'd0);
        check_eq("par_err_pre", err, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        check_eq("par_err_set", err, 1'b1);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        check_eq("par_err_held", err, 1'b1);
        do_reset();
        check_eq("par_err_rst", err, 1'b0);
        check_eq("par_cnt_rst", cnt, 24'h0);
        check_eq("par_empty_rst", empty, 4'hF);
`else
        inject_perr = 1'b1;
        cyc(1'b1, 2'd0, 32'h1234_5678, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        check_eq("nopar_err", err, 1'b0);
        check_eq("nopar_empty", empty, 4'hF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
